// File: rtl/craps_roll_sequencer.sv
// Craps game sequencer: conditions the roll button, spins two dice counters while
// it is held, captures them on release and runs the come-out/point state machine.
module craps_roll_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DB_W            = 18
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       roll,
  output logic [2:0] die1,
  output logic [2:0] die2,
  output logic [3:0] sum,
  output logic [3:0] point,
  output logic       win,
  output logic       loss,
  output logic       roll_done
);

  typedef enum logic [1:0] {COME_OUT, POINT_S, WIN_S, LOSS_S} state_t;

  state_t          state, state_nx;
  logic [3:0]      point_nx;
  logic            roll_m, roll_s, roll_db, roll_db_q;
  logic [DB_W-1:0] db_cnt;
  logic [2:0]      cnt1, cnt2;
  logic [3:0]      s;
  logic            release_ev;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      roll_m <= 1'b0;
      roll_s <= 1'b0;
    end else begin
      roll_m <= roll;
      roll_s <= roll_m;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      roll_db <= 1'b0;
      db_cnt  <= '0;
    end else if (roll_s == roll_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      roll_db <= roll_s;
      db_cnt  <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // cnt2 steps only when cnt1 wraps, so the pair walks all 36 outcomes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt1 <= 3'd1;
      cnt2 <= 3'd1;
    end else if (roll_db) begin
      cnt1 <= (cnt1 == 3'd6) ? 3'd1 : cnt1 + 3'd1;
      if (cnt1 == 3'd6) cnt2 <= (cnt2 == 3'd6) ? 3'd1 : cnt2 + 3'd1;
    end
  end

  assign s          = {1'b0, cnt1} + {1'b0, cnt2};
  assign release_ev = roll_db_q & ~roll_db;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      roll_db_q <= 1'b0;
      die1      <= 3'd1;
      die2      <= 3'd1;
      sum       <= 4'd2;
      roll_done <= 1'b0;
      state     <= COME_OUT;
      point     <= 4'd0;
    end else begin
      roll_db_q <= roll_db;
      roll_done <= release_ev;
      if (release_ev) begin
        die1  <= cnt1;
        die2  <= cnt2;
        sum   <= s;
        state <= state_nx;
        point <= point_nx;
      end
    end
  end

  // WIN/LOSS fall through to the come-out rules: a capture there starts a new game
  always_comb begin
    state_nx = state;
    point_nx = point;
    if (state == POINT_S) begin
      if (s == point) begin
        state_nx = WIN_S;
        point_nx = 4'd0;
      end else if (s == 4'd7) begin
        state_nx = LOSS_S;
        point_nx = 4'd0;
      end
    end else begin
      case (s)
        4'd7, 4'd11:        begin state_nx = WIN_S;  point_nx = 4'd0; end
        4'd2, 4'd3, 4'd12:  begin state_nx = LOSS_S; point_nx = 4'd0; end
        default:            begin state_nx = POINT_S; point_nx = s; end
      endcase
    end
  end

  always_comb begin
    win  = (state == WIN_S);
    loss = (state == LOSS_S);
  end

endmodule

// File: tb/tb_craps_roll_sequencer.sv
// Directed bench for craps_roll_sequencer with a 4-cycle debounce.
module tb_craps_roll_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       roll  = 1'b0;
  logic [2:0] die1, die2;
  logic [3:0] sum, point;
  logic       win, loss, roll_done;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int both_cnt = 0;

  craps_roll_sequencer #(.DEBOUNCE_CYCLES(4), .DB_W(4)) u_dut (
    .clock(clock), .reset(reset), .roll(roll),
    .die1(die1), .die2(die2), .sum(sum), .point(point),
    .win(win), .loss(loss), .roll_done(roll_done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (roll_done) done_cnt++;
    if (win && loss) both_cnt++;
  end

  // hold = posedges the button is seen high; with 2 sync flops and a 4-cycle
  // debounce this equals the number of edges roll_db is high (hold >= 4)
  typedef struct {
    bit do_rst;
    int hold;
    int e_d1, e_d2, e_sum, e_pt, e_win, e_loss;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int d1, input int d2, input int sm,
                           input int pt, input int w, input int l);
    check({tag, " die1"}, int'(die1), d1);
    check({tag, " die2"}, int'(die2), d2);
    check({tag, " sum"}, int'(sum), sm);
    check({tag, " point"}, int'(point), pt);
    check({tag, " win"}, int'(win), w);
    check({tag, " loss"}, int'(loss), l);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic press(input int hold);
    @(negedge clock);
    roll = 1'b1;
    repeat (hold) @(negedge clock);
    roll = 1'b0;
    repeat (12) @(negedge clock);
  endtask

  initial begin
    int base;
    //            rst hold d1 d2 sum pt w l
    vecs[0] = '{1'b0,  5, 6, 1, 7, 0, 1, 0};
    vecs[1] = '{1'b1, 37, 2, 1, 3, 0, 0, 1};
    vecs[2] = '{1'b0, 39, 5, 1, 6, 6, 0, 0};
    vecs[3] = '{1'b1, 38, 3, 1, 4, 4, 0, 0};
    vecs[4] = '{1'b0, 42, 3, 2, 5, 4, 0, 0};
    vecs[5] = '{1'b0, 37, 4, 2, 6, 4, 0, 0};
    vecs[6] = '{1'b0, 37, 5, 2, 7, 0, 0, 1};
    vecs[7] = '{1'b0,  4, 3, 3, 6, 6, 0, 0};
    vecs[8] = '{1'b1,  5, 6, 1, 7, 0, 1, 0};
    vecs[9] = '{1'b0,  4, 4, 2, 6, 6, 0, 0};

    // Reset and idle
    repeat (3) @(negedge clock);
    reset = 1'b0;
    base = done_cnt;
    repeat (20) @(negedge clock);
    check_out("idle", 1, 1, 2, 0, 0, 0);
    check("idle roll_done", done_cnt - base, 0);

    // Pulses shorter than the debounce window must be ignored
    for (int p = 1; p <= 3; p++) begin
      base = done_cnt;
      press(p);
      check_out($sformatf("glitch%0d", p), 1, 1, 2, 0, 0, 0);
      check($sformatf("glitch%0d roll_done", p), done_cnt - base, 0);
    end

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_rst) do_reset();
      base = done_cnt;
      press(vecs[i].hold);
      check_out($sformatf("vec%0d", i), vecs[i].e_d1, vecs[i].e_d2, vecs[i].e_sum,
                vecs[i].e_pt, vecs[i].e_win, vecs[i].e_loss);
      check($sformatf("vec%0d roll_done", i), done_cnt - base, 1);
    end

    // Reset while held and counting; the held press restarts from (1,1)
    base = done_cnt;
    @(negedge clock);
    roll = 1'b1;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    check_out("midreset", 1, 1, 2, 0, 0, 0);
    check("midreset roll_done", int'(roll_done), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    roll = 1'b0;
    repeat (12) @(negedge clock);
    check_out("postreset", 3, 2, 5, 5, 0, 0);
    check("postreset roll_done", done_cnt - base, 1);

    check("win&loss overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/craps_roll_sequencer.md
Name: craps_roll_sequencer

Overview:
- Controller that sequences the two-dice craps game between the raw roll button and the display/LED outputs.
- Conditions the button: 2-flop synchroniser plus debouncer.
- Runs two free-running dice counters while the button is held, captures them on release, and drives the come-out/point game state machine.
- Outputs are binary dice faces plus registered win/loss/point flags; the 7-segment decoders downstream consume die1/die2 and the LEDs consume win/loss.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before the debounced button changes (use 4 in simulation).
- DB_W, 18, debounce counter width; must satisfy 2**DB_W > DEBOUNCE_CYCLES.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- roll  input  1  raw roll button, active-high, asynchronous to clock.
- die1  output  3  captured face of die 1, range 1..6.
- die2  output  3  captured face of die 2, range 1..6.
- sum  output  4  die1+die2 of the last captured roll, range 2..12.
- point  output  4  established point; 0 when not in POINT state.
- win  output  1  high while state = WIN (green LED).
- loss  output  1  high while state = LOSS (red LED).
- roll_done  output  1  one-cycle pulse on the edge a roll is captured.

Behaviour:
- Reset values: die1=1, die2=1, sum=2, point=0, win=0, loss=0, roll_done=0, state=COME_OUT, roll_db=0, debounce count=0, both internal dice counters=1.
- Synchroniser: roll passes through 2 flops to give roll_s.
- Debouncer:
  - If roll_s == roll_db, the count clears to 0.
  - Otherwise the count increments. When the count reaches DEBOUNCE_CYCLES-1 and roll_s still differs, roll_db takes roll_s and the count clears.
  - Pulses shorter than DEBOUNCE_CYCLES never change roll_db.
- Dice counters (cnt1, cnt2):
  - Each edge where roll_db=1: cnt1 advances 1→2→…→6→1.
  - cnt2 advances only on the same edge that cnt1 wraps 6→1 (also 1..6 wrap).
  - Held when roll_db=0. Not cleared between rolls.
  - After H edges with roll_db=1 from (c1,c2): cnt1 = ((c1-1+H) mod 6)+1, and cnt2 advances once per wrap.
- Release detect: roll_db_q = roll_db delayed 1 cycle; release = roll_db_q & ~roll_db.
- On the edge following a cycle with release=1, in a single edge:
  - die1←cnt1, die2←cnt2, sum←cnt1+cnt2.
  - roll_done=1 for that one cycle.
  - state/point/win/loss updated from s = cnt1+cnt2.
- Press (rising roll_db) changes nothing except enabling the counters; the outputs keep the previous roll until release.
- State machine (2-bit: COME_OUT, POINT, WIN, LOSS), evaluated only at capture:
  - COME_OUT: s∈{7,11}→WIN; s∈{2,3,12}→LOSS; else →POINT, point←s.
  - POINT: s==point→WIN, point←0; s==7→LOSS, point←0; else stay, point unchanged.
  - WIN/LOSS: terminal until the next capture. That capture starts a new game and is evaluated exactly as COME_OUT; LEDs update on the same edge, with no intermediate clear cycle.
- win = (state==WIN), loss = (state==LOSS); both are registered and never high together.
- point is nonzero only in POINT.
- Reset mid-roll: everything clears asynchronously.
  - If the button is still held after reset deasserts, roll_db rises after sync + DEBOUNCE_CYCLES.
  - The roll is captured normally on its release.
- Release and a new press cannot coincide: roll_db changes at most once per DEBOUNCE_CYCLES.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, button idle 20 cycles -> die1=1, die2=1, sum=2, point=0, win=0, loss=0, roll_done never pulses.
- From reset, hold so roll_db is high 5 edges, release -> die1=6, die2=1, sum=7, roll_done one pulse, win=1, loss=0.
- From reset, roll_db high 1 edge -> (2,1), sum=3, loss=1; next roll of 3 edges from (2,1) -> (5,1), sum=6, point=6, win=0, loss=0 (new game from LOSS).
- From reset, roll_db high 2 edges -> point=4; roll 6 edges -> (3,2), sum=5, point stays 4; roll 1 edge -> (4,2), sum=6, stay; roll 1 edge -> (5,2), sum=7 -> loss=1, point=0.
- Apply roll pulses of 1, 2 and 3 cycles (shorter than debounce) -> roll_db stays 0, counters and outputs unchanged, no roll_done.
- Assert reset while roll_db=1 and counters mid-count -> all outputs at reset values immediately; keep the button held, release later -> exactly one roll_done and correct capture counted from (1,1).
